serial_loader: RTL and testbench

Parametrised serial boot/program loader for the Marsohod2 Z80 system. It accepts framed images from the UART receiver: magic byte, start address, length, data and optional checksum. It streams the data bytes into any memory bank through a ready/valid write port, and holds the CPU in reset while a frame is in flight. It replaces the fixed 32 KB raw-stream programmer with arbitrary address/length loads, write back-pressure, timeout and error reporting.

---
 rtl/serial_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_serial_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// serial_loader
// Framed serial image loader for the Marsohod2 Z80 system. A frame is
// MAGIC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes [, CSUM]. Data bytes
// are streamed to memory through a ready/valid write port while busy holds
// the CPU in reset. Reports checksum, timeout and overrun errors on err.
// Optional feature: define SERIAL_LOADER_CHECKSUM_EN to expect a trailing
// CSUM byte; the frame is good when the 8-bit sum of ADDR_H..CSUM is zero.

module serial_loader #(
    parameter int         ADDR_W  = 16,
    parameter logic [7:0] MAGIC   = 8'hA5,
    parameter int         TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM = 2'd1;
`endif
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_OVR  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_CSUM,
        S_DRAIN
    } state_t;

    // State entered once the last data byte (or an empty LEN) has been taken.
`ifdef SERIAL_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DRAIN;
`endif

    state_t            state_q, state_d;
    logic [7:0]        addr_h_q, addr_h_d;
    logic [7:0]        len_h_q, len_h_d;
    logic [15:0]       remain_q, remain_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic              busy_d;
    logic              done_d;
    logic [1:0]        err_d;

    logic              wr_accept;
    logic              overrun;
    logic              timed;
    logic              tmo_hit;
    logic [15:0]       rx_len;

    assign wr_accept = wr_en & wr_ready;
    // Only a data byte competes for the write port; a stalled write plus a
    // new data byte means the byte would be lost.
    assign overrun   = (state_q == S_DATA) & rx_valid & wr_en & ~wr_ready;
    // The inter-byte timer runs only while the frame waits on the UART.
    assign timed     = (state_q != S_IDLE) & (state_q != S_DRAIN);
    assign tmo_hit   = timed & ~rx_valid & (tmo_q == TMO_LAST);
    assign rx_len    = {len_h_q, rx_byte};

`ifdef SERIAL_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running 8-bit sum of every byte from ADDR_H through the last data byte.
    always_comb begin
        sum_d = sum_q;
        if (state_q == S_IDLE) begin
            sum_d = 8'd0;
        end else if (rx_valid && state_q != S_CSUM && state_q != S_DRAIN && !overrun) begin
            sum_d = sum_q + rx_byte;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: header bytes advance one state per rx_valid.
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (rx_valid && rx_byte == MAGIC) state_d = S_ADDR_H;
                S_ADDR_H: if (rx_valid) state_d = S_ADDR_L;
                S_ADDR_L: if (rx_valid) state_d = S_LEN_H;
                S_LEN_H:  if (rx_valid) state_d = S_LEN_L;
                S_LEN_L:  if (rx_valid) state_d = (rx_len == 16'd0) ? S_TAIL : S_DATA;
                S_DATA: begin
                    if (overrun) begin
                        state_d = S_IDLE;
                    end else if (rx_valid && remain_q == 16'd1) begin
                        state_d = S_TAIL;
                    end
                end
                S_CSUM:   if (rx_valid) state_d = S_DRAIN;
                S_DRAIN:  if (!wr_en || wr_ready) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered outputs and frame datapath.
    always_comb begin
        wr_en_d   = wr_en & ~wr_ready;
        wr_addr_d = wr_accept ? wr_addr + ADDR_W'(1) : wr_addr;
        wr_data_d = wr_data;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = err;
        addr_h_d  = addr_h_q;
        len_h_d   = len_h_q;
        remain_d  = remain_q;
        tmo_d     = (rx_valid || !timed) ? '0 : tmo_q + CNT_W'(1);

        if (tmo_hit) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            err_d   = ERR_TMO;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid && rx_byte == MAGIC) begin
                        err_d  = ERR_NONE;
                        busy_d = 1'b1;
                    end
                end
                S_ADDR_H: if (rx_valid) addr_h_d = rx_byte;
                S_ADDR_L: if (rx_valid) wr_addr_d = ADDR_W'({addr_h_q, rx_byte});
                S_LEN_H:  if (rx_valid) len_h_d = rx_byte;
                S_LEN_L:  if (rx_valid) remain_d = rx_len;
                S_DATA: begin
                    if (overrun) begin
                        err_d   = ERR_OVR;
                        wr_en_d = 1'b0;
                        busy_d  = 1'b0;
                    end else if (rx_valid) begin
                        wr_data_d = rx_byte;
                        wr_en_d   = 1'b1;
                        remain_d  = remain_q - 16'd1;
                    end
                end
`ifdef SERIAL_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_valid && (sum_q + rx_byte) != 8'd0) err_d = ERR_CSUM;
                end
`endif
                S_DRAIN: begin
                    if (!wr_en || wr_ready) begin
                        busy_d = 1'b0;
                        done_d = (err == ERR_NONE);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_NONE;
            addr_h_q <= 8'd0;
            len_h_q  <= 8'd0;
            remain_q <= 16'd0;
            tmo_q    <= '0;
        end else begin
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            addr_h_q <= addr_h_d;
            len_h_q  <= len_h_d;
            remain_q <= remain_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader
// Self-checking bench for serial_loader (ADDR_W=14, TIMEOUT=100). Frames are
// built from a byte queue; expected writes, checksum and outcome come from a
// frame-level model. Honours SERIAL_LOADER_CHECKSUM_EN like the design.
`timescale 1ns/1ps

module tb_serial_loader;

    localparam int         ADDR_W  = 14;
    localparam int         TIMEOUT = 100;
    localparam logic [7:0] MAGIC_B = 8'hA5;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic [7:0]        rx_byte  = 8'd0;
    logic              rx_valid = 1'b0;
    logic              wr_ready = 1'b1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    int                n_tests = 0;
    int                n_fail  = 0;

    logic [ADDR_W+7:0] got_q[$];
    logic [ADDR_W+7:0] exp_q[$];
    logic [7:0]        data_q[$];
    logic [7:0]        csum_b;
    logic [1:0]        exp_err;
    int                exp_done;
    int                done_cnt   = 0;
    int                busy_falls = 0;
    logic              busy_prev  = 1'b0;
    logic              busy_after_magic;

    serial_loader #(
        .ADDR_W (ADDR_W),
        .MAGIC  (MAGIC_B),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .wr_ready(wr_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Monitor: at the negedge the next posedge's handshake is already settled.
    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
        end else begin
            if (wr_en && wr_ready) got_q.push_back({wr_addr, wr_data});
            if (done) done_cnt++;
            if (busy_prev && !busy) busy_falls++;
            busy_prev = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) tick();
    endtask

    // Frame-level reference: write i lands at (start + i) mod 2^ADDR_W; the
    // checksum makes the byte sum from ADDR_H to CSUM zero mod 256.
    function automatic void model_frame(input logic [15:0] addr, input bit bad);
        int unsigned s;
        int          n;
        int          a;
        n = data_q.size();
        s = int'(addr[15:8]) + int'(addr[7:0]) + (n / 256) + (n % 256);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            s += data_q[i];
            a = (int'(addr) + i) % (1 << ADDR_W);
            exp_q.push_back({a[ADDR_W-1:0], data_q[i]});
        end
        csum_b = 8'((256 - (s % 256)) % 256);
`ifdef SERIAL_LOADER_CHECKSUM_EN
        if (bad) csum_b = csum_b + 8'd1;
        exp_err  = bad ? 2'd1 : 2'd0;
        exp_done = bad ? 0 : 1;
`else
        exp_err  = 2'd0;
        exp_done = bad ? 1 : 1;
`endif
    endfunction

    task automatic send_frame(input logic [15:0] addr, input int gap);
        logic [15:0] len;
        len = 16'(data_q.size());
        send_byte(MAGIC_B);
        busy_after_magic = busy;
        repeat (gap) tick();
        send_byte(addr[15:8]); repeat (gap) tick();
        send_byte(addr[7:0]);  repeat (gap) tick();
        send_byte(len[15:8]);  repeat (gap) tick();
        send_byte(len[7:0]);   repeat (gap) tick();
        for (int i = 0; i < data_q.size(); i++) begin
            send_byte(data_q[i]);
            repeat (gap) tick();
        end
`ifdef SERIAL_LOADER_CHECKSUM_EN
        send_byte(csum_b);
        repeat (gap) tick();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_tests++; if (wr_en !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_en got=%0b want=0", wr_en); end
        n_tests++; if (wr_addr !== '0)   begin n_fail++; $display("FAIL reset_wr_addr got=%h want=0", wr_addr); end
        n_tests++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data got=%h want=0", wr_data); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
        n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%0b want=0", done); end
        n_tests++; if (err !== 2'd0)     begin n_fail++; $display("FAIL reset_err got=%0d want=0", err); end
    endtask

    task automatic test_basic_frame();
        int   base, dbase, fbase;
        logic done_at_fall;
        base = got_q.size(); dbase = done_cnt; fbase = busy_falls;
        data_q = '{8'h11, 8'h22};
        model_frame(16'h4000, 1'b0);
        send_frame(16'h4000, 0);
        wait_idle();
        done_at_fall = done;
        tick();
        n_tests++; if (busy_after_magic !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got=%0b want=1", busy_after_magic); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got=%0b want=0", busy); end
        n_tests++; if (busy_falls - fbase != 1) begin n_fail++; $display("FAIL basic_busy_falls got=%0d want=1", busy_falls - fbase); end
        n_tests++; if (done_at_fall !== 1'b1) begin n_fail++; $display("FAIL basic_done_with_busy_fall got=%0b want=1", done_at_fall); end
        n_tests++; if (done_cnt - dbase != exp_done) begin n_fail++; $display("FAIL basic_done_count got=%0d want=%0d", done_cnt - dbase, exp_done); end
        n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL basic_err got=%0d want=%0d", err, exp_err); end
        n_tests++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL basic_write_count got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_write[%0d] got=%h want=%h", i, got_q[base+i], exp_q[i]); end
        end
    endtask

`ifdef SERIAL_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int base, dbase;
        base = got_q.size(); dbase = done_cnt;
        data_q = '{8'h11, 8'h22};
        model_frame(16'h4000, 1'b1);
        send_frame(16'h4000, 0);
        wait_idle();
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badcsum_busy got=%0b want=0", busy); end
        n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL badcsum_err got=%0d want=%0d", err, exp_err); end
        n_tests++; if (done_cnt - dbase != exp_done) begin n_fail++; $display("FAIL badcsum_done got=%0d want=%0d", done_cnt - dbase, exp_done); end
        n_tests++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL badcsum_write_count got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL badcsum_write[%0d] got=%h want=%h", i, got_q[base+i], exp_q[i]); end
        end
    endtask
`endif

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            logic [15:0] a;
            int          n, gap, base, dbase;
            bit          bad;
            a     = 16'($urandom);
            n     = $urandom_range(1, 12);
            gap   = (f < 2) ? 0 : $urandom_range(0, 3);
            bad   = 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
            bad   = ($urandom_range(0, 2) == 0);
`endif
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
            base = got_q.size(); dbase = done_cnt;
            model_frame(a, bad);
            send_frame(a, gap);
            wait_idle();
            tick();
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy got=%0b want=0", f, busy); end
            n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL rand%0d_err got=%0d want=%0d", f, err, exp_err); end
            n_tests++; if (done_cnt - dbase != exp_done) begin n_fail++; $display("FAIL rand%0d_done got=%0d want=%0d", f, done_cnt - dbase, exp_done); end
            n_tests++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_write_count got=%0d want=%0d", f, got_q.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_write[%0d] got=%h want=%h", f, i, got_q[base+i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_zero_len();
        int base, dbase;
        base = got_q.size(); dbase = done_cnt;
        data_q.delete();
        model_frame(16'h2222, 1'b0);
        send_frame(16'h2222, 0);
        wait_idle();
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zerolen_busy got=%0b want=0", busy); end
        n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL zerolen_err got=%0d want=%0d", err, exp_err); end
        n_tests++; if (done_cnt - dbase != exp_done) begin n_fail++; $display("FAIL zerolen_done got=%0d want=%0d", done_cnt - dbase, exp_done); end
        n_tests++; if (got_q.size() != base) begin n_fail++; $display("FAIL zerolen_writes got=%0d want=0", got_q.size() - base); end
    endtask

    task automatic test_stall();
        int                base, dbase;
        logic [ADDR_W+7:0] w0;
        base = got_q.size(); dbase = done_cnt;
        data_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        model_frame(16'h1230, 1'b0);
        w0 = exp_q[0];
        send_byte(MAGIC_B); send_byte(8'h12); send_byte(8'h30); send_byte(8'h00); send_byte(8'h03);
        wr_ready = 1'b0;
        send_byte(data_q[0]);
        for (int c = 0; c < 20; c++) begin
            n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL stall%0d_wr_en got=%0b want=1", c, wr_en); end
            n_tests++; if (wr_addr !== w0[ADDR_W+7:8]) begin n_fail++; $display("FAIL stall%0d_addr got=%h want=%h", c, wr_addr, w0[ADDR_W+7:8]); end
            n_tests++; if (wr_data !== w0[7:0]) begin n_fail++; $display("FAIL stall%0d_data got=%h want=%h", c, wr_data, w0[7:0]); end
            tick();
        end
        wr_ready = 1'b1;
        repeat (29) tick();
        send_byte(data_q[1]); repeat (49) tick();
        send_byte(data_q[2]); repeat (49) tick();
`ifdef SERIAL_LOADER_CHECKSUM_EN
        send_byte(csum_b);
`endif
        wait_idle();
        tick();
        n_tests++; if (err !== 2'd0) begin n_fail++; $display("FAIL stall_err got=%0d want=0", err); end
        n_tests++; if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL stall_done got=%0d want=1", done_cnt - dbase); end
        n_tests++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL stall_write_count got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_write[%0d] got=%h want=%h", i, got_q[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun();
        int base, dbase;
        base = got_q.size(); dbase = done_cnt;
        send_byte(MAGIC_B); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        wr_ready = 1'b0;
        send_byte(8'h5A);
        tick(); tick();
        send_byte(8'hC3);
        n_tests++; if (err !== 2'd3) begin n_fail++; $display("FAIL overrun_err got=%0d want=3", err); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL overrun_wr_en got=%0b want=0", wr_en); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overrun_busy got=%0b want=0", busy); end
        wr_ready = 1'b1;
        tick();
        n_tests++; if (got_q.size() != base) begin n_fail++; $display("FAIL overrun_writes got=%0d want=0", got_q.size() - base); end
        send_byte(8'h11);
        tick();
        n_tests++; if (err !== 2'd3) begin n_fail++; $display("FAIL overrun_sticky_err got=%0d want=3", err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overrun_idle_busy got=%0b want=0", busy); end
        send_byte(MAGIC_B);
        n_tests++; if (err !== 2'd0) begin n_fail++; $display("FAIL overrun_clear_err got=%0d want=0", err); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL overrun_new_busy got=%0b want=1", busy); end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef SERIAL_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_idle();
        tick();
        n_tests++; if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL overrun_done got=%0d want=1", done_cnt - dbase); end
        n_tests++; if (got_q.size() != base) begin n_fail++; $display("FAIL overrun_writes_after got=%0d want=0", got_q.size() - base); end
    endtask

    task automatic test_timeout();
        int base, dbase;
        base = got_q.size(); dbase = done_cnt;
        send_byte(MAGIC_B); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h04);
        repeat (TIMEOUT - 1) tick();
        n_tests++; if (err !== 2'd0) begin n_fail++; $display("FAIL timeout_early_err got=%0d want=0", err); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early_busy got=%0b want=1", busy); end
        tick();
        n_tests++; if (err !== 2'd2) begin n_fail++; $display("FAIL timeout_err got=%0d want=2", err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy got=%0b want=0", busy); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL timeout_wr_en got=%0b want=0", wr_en); end
        send_byte(8'h00);
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle_busy got=%0b want=0", busy); end
        n_tests++; if (got_q.size() != base) begin n_fail++; $display("FAIL timeout_writes got=%0d want=0", got_q.size() - base); end
        n_tests++; if (done_cnt != dbase) begin n_fail++; $display("FAIL timeout_done got=%0d want=0", done_cnt - dbase); end
    endtask

    task automatic test_wrap_and_reset();
        int base, dbase;
        base = got_q.size(); dbase = done_cnt;
        data_q = '{8'hAA, 8'hBB};
        model_frame(16'h3FFF, 1'b0);
        send_frame(16'h3FFF, 0);
        wait_idle();
        tick();
        n_tests++; if (err !== 2'd0) begin n_fail++; $display("FAIL wrap_err got=%0d want=0", err); end
        n_tests++; if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL wrap_done got=%0d want=1", done_cnt - dbase); end
        n_tests++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL wrap_write_count got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_write[%0d] got=%h want=%h", i, got_q[base+i], exp_q[i]); end
        end
        base = got_q.size(); dbase = done_cnt;
        send_byte(MAGIC_B); send_byte(8'h3F); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h05);
        wr_ready = 1'b0;
        send_byte(8'h77);
        n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL midreset_pending got=%0b want=1", wr_en); end
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (wr_en !== 1'b0)   begin n_fail++; $display("FAIL midreset_wr_en got=%0b want=0", wr_en); end
        n_tests++; if (wr_addr !== '0)   begin n_fail++; $display("FAIL midreset_wr_addr got=%h want=0", wr_addr); end
        n_tests++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL midreset_wr_data got=%h want=0", wr_data); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL midreset_busy got=%0b want=0", busy); end
        n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL midreset_done got=%0b want=0", done); end
        n_tests++; if (err !== 2'd0)     begin n_fail++; $display("FAIL midreset_err got=%0d want=0", err); end
        tick();
        reset    = 1'b0;
        wr_ready = 1'b1;
        repeat (5) tick();
        n_tests++; if (got_q.size() != base) begin n_fail++; $display("FAIL midreset_writes got=%0d want=0", got_q.size() - base); end
        n_tests++; if (done_cnt != dbase) begin n_fail++; $display("FAIL midreset_no_done got=%0d want=0", done_cnt - dbase); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_after got=%0b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
`ifdef SERIAL_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_random_frames();
        test_zero_len();
        test_stall();
        test_overrun();
        test_timeout();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
